// File: rtl/wb_stage_if.sv
// Bus between the MEM stage / register file and the write-back stage.
// The master side presents MEM-stage results and pipeline control.
// The slave side (wb_stage) drives the register-file write port and status.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             mem_valid;
  logic [5:0]       mem_ctrl;
  logic [4:0]       mem_rd_add;
  logic [31:0]      mem_alu_result;
  logic [31:0]      mem_read_data;
  logic [31:0]      mem_pc_4;

  logic [4:0]       rd_add;
  logic [31:0]      data;
  logic             reg_write;
  logic             wb_valid;
  logic             ld_misalign;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output stall, flush, mem_valid, mem_ctrl, mem_rd_add,
           mem_alu_result, mem_read_data, mem_pc_4,
    input  rd_add, data, reg_write, wb_valid, ld_misalign, retired_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_ctrl, mem_rd_add,
           mem_alu_result, mem_read_data, mem_pc_4,
    output rd_add, data, reg_write, wb_valid, ld_misalign, retired_count
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load alignment/extension,
// result selection, register-file write strobe (active low) and a
// retired-instruction counter. Outputs depend only on the WB registers.
module wb_stage #(
  parameter int CNT_W      = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  wb_stage_if.slave  wb
);

  logic             valid_q, valid_d;
  logic             fresh_q, fresh_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             regWe;
  logic [1:0]       wbSel;
  logic [1:0]       ldSize;
  logic             ldUnsigned;
  logic [1:0]       addr;
  logic [1:0]       byteSel;
  logic             halfUpper;
  logic [7:0]       byteLane;
  logic [15:0]      halfLane;
  logic [31:0]      loadData;
  logic             isHalf;
  logic             isWord;
  logic             misalign;
  logic [31:0]      wbData;

  assign regWe      = ctrl_q[0];
  assign wbSel      = ctrl_q[2:1];
  assign ldSize     = ctrl_q[4:3];
  assign ldUnsigned = ctrl_q[5];
  assign addr       = alu_q[1:0];

  // Next-state of the WB register: flush beats stall beats a normal load;
  // fresh marks the first cycle an instruction sits in WB.
  always_comb begin
    valid_d = valid_q;
    fresh_d = 1'b0;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    if (wb.flush) begin
      valid_d = 1'b0;
    end else if (!wb.stall) begin
      valid_d = wb.mem_valid;
      fresh_d = 1'b1;
      ctrl_d  = wb.mem_ctrl;
      rd_d    = wb.mem_rd_add;
      alu_d   = wb.mem_alu_result;
      rdata_d = wb.mem_read_data;
      pc4_d   = wb.mem_pc_4;
    end
    cnt_d = (valid_q && fresh_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Pipeline register and counter with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pick the byte/half lane addressed by the load and extend it to 32 bits.
  always_comb begin
    byteSel   = BIG_ENDIAN ? (2'd3 - addr) : addr;
    halfUpper = BIG_ENDIAN ? ~addr[1] : addr[1];
    byteLane  = rdata_q[{byteSel, 3'b000} +: 8];
    halfLane  = halfUpper ? rdata_q[31:16] : rdata_q[15:0];
    case (ldSize)
      2'b01:   loadData = ldUnsigned ? {16'h0000, halfLane}
                                     : {{16{halfLane[15]}}, halfLane};
      2'b10:   loadData = ldUnsigned ? {24'h000000, byteLane}
                                     : {{24{byteLane[7]}}, byteLane};
      default: loadData = rdata_q;
    endcase
  end

  // Misalignment check and write-back source selection.
  always_comb begin
    isHalf   = (ldSize == 2'b01);
    isWord   = (ldSize == 2'b00) || (ldSize == 2'b11);
    misalign = valid_q && (wbSel == 2'b01) &&
               ((isHalf && addr[0]) || (isWord && (addr != 2'b00)));
    case (wbSel)
      2'b01:   wbData = loadData;
      2'b10:   wbData = pc4_q;
      default: wbData = alu_q;
    endcase
  end

  assign wb.rd_add        = rd_q;
  assign wb.data          = wbData;
  assign wb.wb_valid      = valid_q;
  assign wb.ld_misalign   = misalign;
  assign wb.reg_write     = ~(valid_q && fresh_q && regWe &&
                              (rd_q != 5'd0) && !misalign);
  assign wb.retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven vectors fed through a
// scoreboard queue, plus hand-written stall/flush and async-reset sequences.
module tb_wb_stage;

  typedef struct {
    logic        valid;
    logic [5:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic        expRegWrite;
    logic        expValid;
    logic        expMisalign;
    logic        chkPayload;
    logic [31:0] expCount;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   cnt;
  vec_t expQ[$];
  vec_t table_v[14];
  vec_t v;

  wb_stage_if #(.CNT_W(32)) bus ();

  wb_stage #(.CNT_W(32), .BIG_ENDIAN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic vld, input logic [5:0] ctrl,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [31:0] pc4,
                              input logic [4:0] eRd, input logic [31:0] eData,
                              input logic eRw, input logic eValid,
                              input logic eMis);
    vec_t r;
    r.valid       = vld;
    r.ctrl        = ctrl;
    r.rd          = rd;
    r.alu         = alu;
    r.rdata       = rdata;
    r.pc4         = pc4;
    r.expRd       = eRd;
    r.expData     = eData;
    r.expRegWrite = eRw;
    r.expValid    = eValid;
    r.expMisalign = eMis;
    r.chkPayload  = 1'b1;
    r.expCount    = 32'd0;
    return r;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one MEM-stage record at the falling edge, queue its expectation,
  // then step past the next rising edge.
  task automatic applyStimulus(input vec_t sv, input logic st, input logic fl);
    @(negedge clk);
    bus.stall          = st;
    bus.flush          = fl;
    bus.mem_valid      = sv.valid;
    bus.mem_ctrl       = sv.ctrl;
    bus.mem_rd_add     = sv.rd;
    bus.mem_alu_result = sv.alu;
    bus.mem_read_data  = sv.rdata;
    bus.mem_pc_4       = sv.pc4;
    expQ.push_back(sv);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it against the WB outputs.
  task automatic checkOutput(input string tag);
    vec_t e;
    if (expQ.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = expQ.pop_front();
    checkField({tag, ".reg_write"}, {31'd0, bus.reg_write}, {31'd0, e.expRegWrite});
    checkField({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, e.expValid});
    checkField({tag, ".ld_misalign"}, {31'd0, bus.ld_misalign}, {31'd0, e.expMisalign});
    checkField({tag, ".retired_count"}, bus.retired_count, e.expCount);
    if (e.chkPayload) begin
      checkField({tag, ".rd_add"}, {27'd0, bus.rd_add}, {27'd0, e.expRd});
      checkField({tag, ".data"}, bus.data, e.expData);
    end
  endtask

  initial begin
    logic [31:0] rw;
    rw     = 32'h80FF_7F01;
    checks = 0;
    fails  = 0;
    cnt    = 0;

    table_v[0]  = mk(1, 6'b000001, 5'd5,  32'h1234_5678, 32'h0, 32'h0,
                     5'd5,  32'h1234_5678, 1'b0, 1'b1, 1'b0);
    table_v[1]  = mk(1, 6'b010011, 5'd3,  32'h0000_0000, rw, 32'h0,
                     5'd3,  32'hFFFF_FF80, 1'b0, 1'b1, 1'b0);
    table_v[2]  = mk(1, 6'b110011, 5'd3,  32'h0000_0001, rw, 32'h0,
                     5'd3,  32'h0000_00FF, 1'b0, 1'b1, 1'b0);
    table_v[3]  = mk(1, 6'b001011, 5'd3,  32'h0000_0002, rw, 32'h0,
                     5'd3,  32'h0000_7F01, 1'b0, 1'b1, 1'b0);
    table_v[4]  = mk(1, 6'b101011, 5'd3,  32'h0000_0000, rw, 32'h0,
                     5'd3,  32'h0000_80FF, 1'b0, 1'b1, 1'b0);
    table_v[5]  = mk(1, 6'b000011, 5'd3,  32'h0000_0002, rw, 32'h0,
                     5'd3,  32'h80FF_7F01, 1'b1, 1'b1, 1'b1);
    table_v[6]  = mk(1, 6'b000011, 5'd8,  32'h0000_0100, rw, 32'h0,
                     5'd8,  32'h80FF_7F01, 1'b0, 1'b1, 1'b0);
    table_v[7]  = mk(1, 6'b010011, 5'd3,  32'h0000_0003, rw, 32'h0,
                     5'd3,  32'h0000_0001, 1'b0, 1'b1, 1'b0);
    table_v[8]  = mk(1, 6'b000101, 5'd31, 32'h0000_0040, 32'h0, 32'h0000_0104,
                     5'd31, 32'h0000_0104, 1'b0, 1'b1, 1'b0);
    table_v[9]  = mk(1, 6'b000101, 5'd0,  32'h0000_0040, 32'h0, 32'h0000_0104,
                     5'd0,  32'h0000_0104, 1'b1, 1'b1, 1'b0);
    table_v[10] = mk(1, 6'b000000, 5'd9,  32'hAAAA_5555, 32'h0, 32'h0,
                     5'd9,  32'hAAAA_5555, 1'b1, 1'b1, 1'b0);
    table_v[11] = mk(1, 6'b000111, 5'd4,  32'hDEAD_BEEF, rw, 32'h0000_0200,
                     5'd4,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    table_v[12] = mk(0, 6'b000001, 5'd6,  32'h0000_0001, 32'h0, 32'h0,
                     5'd6,  32'h0000_0001, 1'b1, 1'b0, 1'b0);
    table_v[13] = mk(1, 6'b010011, 5'd2,  32'h0000_0002, rw, 32'h0,
                     5'd2,  32'h0000_007F, 1'b0, 1'b1, 1'b0);

    // Reset asserted from time zero with quiet inputs.
    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mem_ctrl       = 6'd0;
    bus.mem_rd_add     = 5'd0;
    bus.mem_alu_result = 32'd0;
    bus.mem_read_data  = 32'd0;
    bus.mem_pc_4       = 32'd0;
    #3;
    checkField("reset.reg_write", {31'd0, bus.reg_write}, 32'd1);
    checkField("reset.data", bus.data, 32'd0);
    checkField("reset.rd_add", {27'd0, bus.rd_add}, 32'd0);
    checkField("reset.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    checkField("reset.retired_count", bus.retired_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle cycles after reset release.
    for (int i = 0; i < 3; i++) begin
      v = mk(0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      v.expCount = 32'd0;
      applyStimulus(v, 1'b0, 1'b0);
      checkOutput($sformatf("idle%0d", i));
    end

    // Table of single-cycle instructions; the counter lags by one cycle.
    for (int i = 0; i < 14; i++) begin
      v = table_v[i];
      v.expCount = cnt;
      applyStimulus(v, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d", i));
      if (table_v[i].valid) cnt++;
    end

    // ALU write to r7 followed by three stall cycles with noise on inputs.
    v = mk(1, 6'b000001, 5'd7, 32'h0000_0077, 32'd0, 32'd0,
           5'd7, 32'h0000_0077, 1'b0, 1'b1, 1'b0);
    v.expCount = cnt;
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("stallLoad");
    cnt++;
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 6'b000001, 5'($urandom_range(1, 31)), $urandom, $urandom, $urandom,
             5'd7, 32'h0000_0077, 1'b1, 1'b1, 1'b0);
      v.expCount = cnt;
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput($sformatf("stall%0d", i));
    end

    // Flush together with stall leaves a bubble that is never counted.
    v = mk(1, 6'b000001, 5'd12, 32'h0000_0099, 32'd0, 32'd0,
           5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    v.chkPayload = 1'b0;
    v.expCount   = cnt;
    applyStimulus(v, 1'b1, 1'b1);
    checkOutput("flushStall");
    v = mk(0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    v.expCount = cnt;
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("afterFlush");

    // Asynchronous reset in the middle of a write cycle.
    v = mk(1, 6'b000001, 5'd5, 32'h0000_0055, 32'd0, 32'd0,
           5'd5, 32'h0000_0055, 1'b0, 1'b1, 1'b0);
    v.expCount = cnt;
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("preAsyncReset");
    #2;
    rst_n = 1'b0;
    #1;
    checkField("asyncReset.reg_write", {31'd0, bus.reg_write}, 32'd1);
    checkField("asyncReset.retired_count", bus.retired_count, 32'd0);
    checkField("asyncReset.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    checkField("asyncReset.data", bus.data, 32'd0);
    checkField("asyncReset.rd_add", {27'd0, bus.rd_add}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    checkField("scoreboard.leftover", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the 5-stage pipeline: the MEM/WB pipeline register plus the register-file write side.
- Captures the MEM-stage result each cycle.
- Aligns and extends load data, selects ALU, load or link data.
- Drives the register-file write port (rd_add, data, reg_write) that the decode stage consumes.
- Also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
BIG_ENDIAN, 1, 1: byte offset 0 is bits [31:24]; 0: byte offset 0 is bits [7:0]

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold WB register contents
flush  input  1  load a bubble instead of MEM contents
mem_valid  input  1  MEM stage holds a real instruction
mem_ctrl  input  6  [0] reg write enable, [2:1] wb_sel (00 ALU, 01 load, 10 link, 11 ALU), [4:3] ld_size (00 word, 01 half, 10 byte, 11 word), [5] ld_unsigned
mem_rd_add  input  5  destination register
mem_alu_result  input  32  ALU result / load byte address
mem_read_data  input  32  raw word from data memory
mem_pc_4  input  32  PC+4 of instruction (link value)
rd_add  output  5  register-file write address
data  output  32  register-file write data (also forwarding source)
reg_write  output  1  ACTIVE-LOW write strobe, drives register file wr_n
wb_valid  output  1  WB holds a real instruction
ld_misalign  output  1  misaligned load detected in WB
retired_count  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (reset=0, asynchronous):
  - all WB registers clear; fresh=0; retired_count=0.
  - Outputs: rd_add=0, data=0, reg_write=1, wb_valid=0, ld_misalign=0.
  - Reset mid-stall or mid-flush discards everything.
- WB register update on posedge clk, priority flush > stall > load:
  - flush=1: valid=0, fresh=0, other fields don't-care.
  - stall=1 (flush=0): all fields held; fresh cleared to 0.
  - otherwise: capture mem_valid, mem_ctrl, mem_rd_add, mem_alu_result, mem_read_data, mem_pc_4; fresh=1.
- Latency: values presented at edge N appear on outputs during cycle N+1. All outputs are combinational from WB registers only; no input-to-output path.
- wb_valid = valid.
- Load extraction, addr = stored alu_result[1:0]:
  - byte: lane addr selected (BIG_ENDIAN=1: addr 0 → [31:24], 3 → [7:0]); zero-extended if ld_unsigned, else sign-extended.
  - half: lane addr[1] (BIG_ENDIAN=1: 0 → [31:16], 1 → [15:0]); extended as for byte.
  - word: raw word.
- ld_misalign = valid & wb_sel==01 & ((half & addr[0]) | (word & addr[1:0]!=0)).
- data:
  - wb_sel 00/11: alu_result.
  - 01: extracted load (raw word forwarded even if misaligned).
  - 10: pc_4.
- rd_add = stored rd.
- reg_write = 0 only when all of: valid, fresh, reg write enable, rd!=0, !ld_misalign. Otherwise 1.
  - Write to r0 is never strobed.
  - A stalled instruction writes exactly once (first cycle only).
- retired_count increments by 1 at a posedge when valid & fresh, whether or not the instruction writes or is misaligned; wraps to 0 after all-ones.
- flush and stall together: flush wins; the bubble does not count.

Test Plan:
- Reset, then release with mem_valid=0 for 3 cycles → reg_write=1, data=0, rd_add=0, retired_count=0 throughout.
- ALU write, mem_ctrl=6'b000001, rd=5, alu=32'h1234_5678 → next cycle rd_add=5, data=32'h1234_5678, reg_write=0 for one cycle; retired_count 0→1.
- Loads from mem_read_data=32'h80FF_7F01, BIG_ENDIAN=1:
  - signed byte, addr 0 → 32'hFFFF_FF80.
  - unsigned byte, addr 1 → 32'h0000_00FF.
  - signed half, addr 2 → 32'h0000_7F01.
  - unsigned half, addr 0 → 32'h0000_80FF.
  - word, addr 2 → ld_misalign=1, reg_write=1.
- Link, wb_sel=10, rd=31, pc_4=32'h0000_0104 → data=32'h0000_0104, reg_write=0. Same with rd=0 → reg_write=1, counter still increments.
- Load ALU write rd=7, then stall=1 for 3 cycles → reg_write=0 only in the first cycle, outputs held for 4 cycles, counter +1 only. Assert flush with stall → wb_valid=0 next cycle.
- Pull reset low asynchronously mid-cycle while reg_write=0 → reg_write=1 and retired_count=0 immediately, without waiting for a clock edge.
